// File: rtl/spi_pkg.sv
// Shared types and register-map constants for the memory-mapped SPI master.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    HIGH,
    LOW,
    TRAIL
  } spi_state_t;

  localparam logic [3:0] OFS_CLKDIV = 4'h0;
  localparam logic [3:0] OFS_STATUS = 4'h4;
  localparam logic [3:0] OFS_TXDATA = 4'h8;
  localparam logic [3:0] OFS_RXDATA = 4'hC;

  localparam int unsigned STAT_BUSY = 0;
  localparam int unsigned STAT_DONE = 1;
  localparam int unsigned STAT_OVR  = 2;
  localparam int unsigned STAT_IE   = 3;
  // Written together with STAT_IE=0 to clear the interrupt enable.
  localparam int unsigned STAT_IE_CLR = 4;

  localparam logic [2:0] BIT_LAST = 3'd7;

endpackage

// File: rtl/spi_master_ctrl_if.sv
// Processor data-bus view of the SPI master register window.
interface spi_master_ctrl_if;

  logic [12:0] dataadr;
  logic [31:0] writedata;
  logic        memwrite;
  logic        sel;
  logic [31:0] readdata;

  modport master (
    output dataadr,
    output writedata,
    output memwrite,
    input  sel,
    input  readdata
  );

  modport slave (
    input  dataadr,
    input  writedata,
    input  memwrite,
    output sel,
    output readdata
  );

endinterface

// File: rtl/spi_clk_div.sv
// Half-period timer: loadable down-counter that holds at zero and flags it with tick.
module spi_clk_div (
  input  logic       clk,
  input  logic       reset,
  input  logic       reload,
  input  logic [7:0] load_val,
  output logic       tick
);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (reload) begin
      cnt_d = load_val;
    end else if (cnt_q != 8'd0) begin
      cnt_d = cnt_q - 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == 8'd0);

endmodule

// File: rtl/spi_master_ctrl.sv
// Memory-mapped SPI mode-0 master: register window, transfer FSM and RX/TX shifters.
// Optional feature macro: SPI_IRQ_EN (interrupt enable bit and registered irq output).
module spi_master_ctrl
  import spi_pkg::*;
#(
  parameter logic [12:0] BASE_ADDR = 13'h1000,
  parameter logic [7:0]  DIV_RESET = 8'd24
) (
  input  logic             clk,
  input  logic             reset,
  spi_master_ctrl_if.slave bus,
  output logic             spi_sclk,
  output logic             spi_mosi,
  input  logic             spi_miso,
  output logic             spi_cs_n,
  output logic             irq
);

  spi_state_t state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] tx_sh_q, tx_sh_d;
  logic [7:0] rx_sh_q, rx_sh_d;
  logic       mosi_q, mosi_d;
  logic [7:0] div_lat_q, div_lat_d;
  logic [7:0] clkdiv_q, clkdiv_d;
  logic [7:0] txdata_q, txdata_d;
  logic [7:0] rxdata_q, rxdata_d;
  logic       done_q, done_d;
  logic       ovr_q, ovr_d;
  logic       ie_q;

  logic       sel;
  logic [3:0] ofs;
  logic       wr, wr_clkdiv, wr_status, wr_txdata;
  logic       busy, start, finish;
  logic       div_reload, div_tick;
  logic [7:0] div_load;
  logic [31:0] rdata;

  logic unused_bus;
  assign unused_bus = ^{bus.writedata[31:8], bus.writedata[4:3], bus.dataadr[1:0]};

  // Bus decode
  assign sel       = (bus.dataadr[12:4] == BASE_ADDR[12:4]);
  assign ofs       = {bus.dataadr[3:2], 2'b00};
  assign wr        = bus.memwrite & sel;
  assign wr_clkdiv = wr & (ofs == OFS_CLKDIV);
  assign wr_status = wr & (ofs == OFS_STATUS);
  assign wr_txdata = wr & (ofs == OFS_TXDATA);

  assign busy   = (state_q != IDLE);
  assign start  = (state_q == IDLE) & wr_txdata;
  assign finish = (state_q == TRAIL) & div_tick;

  spi_clk_div u_clk_div (
    .clk      (clk),
    .reset    (reset),
    .reload   (div_reload),
    .load_val (div_load),
    .tick     (div_tick)
  );

  // Transfer FSM: one state per SPI half-period, divider reloaded on each state change.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    tx_sh_d    = tx_sh_q;
    rx_sh_d    = rx_sh_q;
    mosi_d     = mosi_q;
    div_lat_d  = div_lat_q;
    txdata_d   = txdata_q;
    rxdata_d   = rxdata_q;
    div_reload = 1'b0;
    div_load   = div_lat_q;

    unique case (state_q)
      IDLE: begin
        if (wr_txdata) begin
          state_d    = SETUP;
          bit_cnt_d  = 3'd0;
          tx_sh_d    = bus.writedata[7:0];
          txdata_d   = bus.writedata[7:0];
          mosi_d     = bus.writedata[7];
          // The divisor is frozen here so CLKDIV stores mid-transfer apply next time.
          div_lat_d  = clkdiv_q;
          div_load   = clkdiv_q;
          div_reload = 1'b1;
        end
      end
      SETUP: begin
        if (div_tick) begin
          state_d    = HIGH;
          rx_sh_d    = {rx_sh_q[6:0], spi_miso};
          div_reload = 1'b1;
        end
      end
      HIGH: begin
        if (div_tick) begin
          div_reload = 1'b1;
          if (bit_cnt_q == BIT_LAST) begin
            state_d = TRAIL;
          end else begin
            state_d   = LOW;
            tx_sh_d   = {tx_sh_q[6:0], 1'b0};
            mosi_d    = tx_sh_q[6];
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      LOW: begin
        if (div_tick) begin
          state_d    = HIGH;
          rx_sh_d    = {rx_sh_q[6:0], spi_miso};
          div_reload = 1'b1;
        end
      end
      TRAIL: begin
        if (div_tick) begin
          state_d    = IDLE;
          rxdata_d   = rx_sh_q;
          div_reload = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Register file next-state; a completing transfer wins over a concurrent done clear.
  always_comb begin
    clkdiv_d = clkdiv_q;
    done_d   = done_q;
    ovr_d    = ovr_q;

    if (wr_clkdiv) begin
      clkdiv_d = bus.writedata[7:0];
    end

    if (wr_status && bus.writedata[STAT_DONE]) begin
      done_d = 1'b0;
    end
    if (start) begin
      done_d = 1'b0;
    end else if (finish) begin
      done_d = 1'b1;
    end

    if (wr_txdata && busy) begin
      ovr_d = 1'b1;
    end else if (wr_status && bus.writedata[STAT_OVR]) begin
      ovr_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      bit_cnt_q <= 3'd0;
      tx_sh_q   <= 8'd0;
      rx_sh_q   <= 8'd0;
      mosi_q    <= 1'b0;
      div_lat_q <= DIV_RESET;
      clkdiv_q  <= DIV_RESET;
      txdata_q  <= 8'd0;
      rxdata_q  <= 8'd0;
      done_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      tx_sh_q   <= tx_sh_d;
      rx_sh_q   <= rx_sh_d;
      mosi_q    <= mosi_d;
      div_lat_q <= div_lat_d;
      clkdiv_q  <= clkdiv_d;
      txdata_q  <= txdata_d;
      rxdata_q  <= rxdata_d;
      done_q    <= done_d;
      ovr_q     <= ovr_d;
    end
  end

`ifdef SPI_IRQ_EN
  logic ie_d;
  logic irq_q;

  always_comb begin
    ie_d = ie_q;
    if (wr_status) begin
      if (bus.writedata[STAT_IE]) begin
        ie_d = 1'b1;
      end else if (bus.writedata[STAT_IE_CLR]) begin
        ie_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ie_q  <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      ie_q  <= ie_d;
      irq_q <= done_q & ie_q;
    end
  end

  assign irq = irq_q;
`else
  assign ie_q = 1'b0;
  assign irq  = 1'b0;
`endif

  // Register read mux
  always_comb begin
    rdata = 32'd0;
    if (sel) begin
      case (ofs)
        OFS_CLKDIV: rdata = {24'd0, clkdiv_q};
        OFS_STATUS: rdata = {28'd0, ie_q, ovr_q, done_q, busy};
        OFS_TXDATA: rdata = {24'd0, txdata_q};
        OFS_RXDATA: rdata = {24'd0, rxdata_q};
        default:    rdata = 32'd0;
      endcase
    end
  end

  assign bus.sel      = sel;
  assign bus.readdata = rdata;

  assign spi_sclk = (state_q == HIGH);
  assign spi_cs_n = (state_q == IDLE);
  assign spi_mosi = mosi_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Self-checking bench for spi_master_ctrl: timeline-based reference model plus directed pins.
`timescale 1ns/1ps
module tb_spi_master_ctrl;

  localparam logic [12:0] BASE = 13'h1000;

  logic clk;
  logic reset;
  logic spi_sclk, spi_mosi, spi_miso, spi_cs_n, irq;
  logic loop, miso_r, miso_rand;
  int   n_cmp, n_fail;

  spi_master_ctrl_if bus ();

  spi_master_ctrl #(
    .BASE_ADDR (BASE),
    .DIV_RESET (8'd24)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .spi_sclk (spi_sclk),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso),
    .spi_cs_n (spi_cs_n),
    .irq      (irq)
  );

  assign spi_miso = loop ? spi_mosi : miso_r;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: a transfer is a timeline of 17 half-periods of (D+1) cycles each.
  bit         m_valid;
  bit         m_active;
  int         m_k, m_D;
  logic [7:0] m_tx, m_sh, m_rx, m_clkdiv, m_txreg;
  bit         m_done, m_ovr, m_ie, m_irq, m_mosi;

  always @(posedge clk) begin
    bit         old_done, old_ie, old_active, old_mosi, samp, mwr;
    logic [3:0] ofs;
    int         h;
    if (reset) begin
      m_valid = 1; m_active = 0; m_k = 0; m_D = 0; m_tx = 0; m_sh = 0; m_rx = 0;
      m_clkdiv = 8'd24; m_txreg = 0; m_done = 0; m_ovr = 0; m_ie = 0; m_irq = 0; m_mosi = 0;
    end else if (m_valid) begin
      old_done = m_done; old_ie = m_ie; old_active = m_active; old_mosi = m_mosi;
      samp = loop ? old_mosi : miso_r;
      mwr  = bus.memwrite && (bus.dataadr[12:4] == BASE[12:4]);
      ofs  = {bus.dataadr[3:2], 2'b00};
      if (mwr && ofs == 4'h4) begin
        if (bus.writedata[1]) m_done = 0;
        if (bus.writedata[2]) m_ovr = 0;
`ifdef SPI_IRQ_EN
        if (bus.writedata[3]) m_ie = 1;
        else if (bus.writedata[4]) m_ie = 0;
`endif
      end
      if (m_active) begin
        if (m_k == 17 * (m_D + 1) - 1) begin
          m_active = 0; m_done = 1; m_rx = m_sh;
        end else begin
          m_k++;
          h = m_k / (m_D + 1);
          if ((m_k % (m_D + 1)) == 0 && (h % 2) == 1) m_sh = {m_sh[6:0], samp};
          if (h <= 15) m_mosi = m_tx[7 - h / 2];
        end
      end
      if (mwr && ofs == 4'h0) m_clkdiv = bus.writedata[7:0];
      if (mwr && ofs == 4'h8) begin
        if (old_active) begin
          m_ovr = 1;
        end else begin
          m_active = 1; m_k = 0; m_D = int'(m_clkdiv); m_tx = bus.writedata[7:0];
          m_txreg = bus.writedata[7:0]; m_mosi = bus.writedata[7]; m_done = 0;
        end
      end
`ifdef SPI_IRQ_EN
      m_irq = old_done & old_ie;
`else
      m_irq = 0;
`endif
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    logic [31:0] exp_rd;
    bit          exp_sel;
    int          h;
    if (m_valid) begin
      exp_sel = (bus.dataadr[12:4] == BASE[12:4]);
      exp_rd  = 32'd0;
      if (exp_sel) begin
        case (bus.dataadr[3:2])
          2'd0: exp_rd = {24'd0, m_clkdiv};
          2'd1: exp_rd = {28'd0, m_ie, m_ovr, m_done, m_active};
          2'd2: exp_rd = {24'd0, m_txreg};
          default: exp_rd = {24'd0, m_rx};
        endcase
      end
      h = m_k / (m_D + 1);
      check("sel", {31'd0, bus.sel}, {31'd0, exp_sel});
      check("readdata", bus.readdata, exp_rd);
      check("sclk", {31'd0, spi_sclk}, {31'd0, m_active && (h % 2) == 1});
      check("cs_n", {31'd0, spi_cs_n}, {31'd0, !m_active});
      check("mosi", {31'd0, spi_mosi}, {31'd0, m_mosi});
      check("irq", {31'd0, irq}, {31'd0, m_irq});
    end
  end

  initial begin
    miso_r = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (miso_rand) miso_r = 1'($urandom);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic wr(input logic [12:0] a, input logic [31:0] d);
    @(posedge clk);
    #2;
    bus.dataadr = a; bus.writedata = d; bus.memwrite = 1'b1;
    @(posedge clk);
    #2;
    bus.memwrite = 1'b0;
  endtask

  task automatic rd(input logic [12:0] a, output logic [31:0] d);
    @(posedge clk);
    #2;
    bus.dataadr = a;
    @(negedge clk);
    d = bus.readdata;
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #2;
    reset = 1'b1;
    @(posedge clk);
    #2;
    reset = 1'b0;
  endtask

  // Follows one transfer from the cycle after its start store until cs_n rises.
  task automatic run_xfer(output int busy_n, output int hi_n, output logic [7:0] bits);
    logic prev;
    prev = 1'b0; busy_n = 0; hi_n = 0; bits = 8'd0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (spi_cs_n) break;
      busy_n++;
      if (spi_sclk) begin
        hi_n++;
        if (!prev) bits = {bits[6:0], spi_mosi};
      end
      prev = spi_sclk;
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!spi_cs_n && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", {31'd0, spi_cs_n}, 32'd1);
  endtask

  initial begin
    logic [31:0] d;
    logic [7:0]  bits;
    int          busy_n, hi_n, r;
    logic [12:0] a;
    n_cmp = 0; n_fail = 0;
    reset = 1'b1; loop = 1'b1; miso_rand = 1'b0;
    bus.dataadr = BASE; bus.writedata = 32'd0; bus.memwrite = 1'b0;
    #22;
    reset = 1'b0;

    // Register reset values
    rd(BASE + 13'h0, d); check("rst_clkdiv", d, 32'd24);
    rd(BASE + 13'h4, d); check("rst_status", d, 32'd0);
    rd(BASE + 13'hC, d); check("rst_rxdata", d, 32'd0);
    check("rst_pins", {29'd0, spi_cs_n, spi_sclk, irq}, 32'h4);

    // Basic loopback transfer at full speed
    wr(BASE + 13'h0, 32'd0);
    loop = 1'b1;
    wr(BASE + 13'h8, 32'hA5);
    run_xfer(busy_n, hi_n, bits);
    check("basic_busy", busy_n, 32'd17);
    check("basic_pulses", hi_n, 32'd8);
    check("basic_mosi", {24'd0, bits}, 32'hA5);
    rd(BASE + 13'hC, d); check("basic_rx", d, 32'hA5);
    rd(BASE + 13'h4, d); check("basic_status", d, 32'h2);

    // Divided clock with miso held high
    wr(BASE + 13'h0, 32'd3);
    loop = 1'b0; miso_rand = 1'b0; miso_r = 1'b1;
    wr(BASE + 13'h8, 32'h3C);
    run_xfer(busy_n, hi_n, bits);
    check("div_busy", busy_n, 32'd68);
    check("div_high", hi_n, 32'd32);
    check("div_mosi", {24'd0, bits}, 32'h3C);
    rd(BASE + 13'hC, d); check("div_rx", d, 32'hFF);

    // Overrun: second store lands mid-transfer and is dropped
    wr(BASE + 13'h0, 32'd1);
    loop = 1'b1;
    wr(BASE + 13'h8, 32'h11);
    repeat (3) @(posedge clk);
    wr(BASE + 13'h8, 32'h22);
    wait_idle();
    rd(BASE + 13'h4, d); check("ovr_status", d, 32'h6);
    rd(BASE + 13'h8, d); check("ovr_txdata", d, 32'h11);
    rd(BASE + 13'hC, d); check("ovr_rx", d, 32'h11);
    wr(BASE + 13'h4, 32'h6);
    rd(BASE + 13'h4, d); check("ovr_clear", d, 32'h0);

    // Reset mid-transfer
    wr(BASE + 13'h8, 32'h5A);
    repeat (8) @(posedge clk);
    pulse_reset();
    @(negedge clk);
    check("mid_rst_pins", {30'd0, spi_cs_n, spi_sclk}, 32'h2);
    rd(BASE + 13'h4, d); check("mid_rst_status", d, 32'h0);
    rd(BASE + 13'hC, d); check("mid_rst_rx", d, 32'h0);
    wr(BASE + 13'h0, 32'd0);

    // Interrupt behaviour
    wr(BASE + 13'h4, 32'h8);
    wr(BASE + 13'h8, 32'h81);
    run_xfer(busy_n, hi_n, bits);
    check("irq_mosi", {24'd0, bits}, 32'h81);
`ifdef SPI_IRQ_EN
    check("irq_at_done", {31'd0, irq}, 32'd0);
    @(negedge clk);
    check("irq_rise", {31'd0, irq}, 32'd1);
    wr(BASE + 13'h4, 32'h2);
    @(negedge clk);
    check("irq_hold", {31'd0, irq}, 32'd1);
    @(negedge clk);
    check("irq_drop", {31'd0, irq}, 32'd0);
`else
    @(negedge clk);
    check("irq_off", {31'd0, irq}, 32'd0);
    rd(BASE + 13'h4, d); check("ie_off", d, 32'h2);
`endif

    // Randomised traffic against the model
    miso_rand = 1'b1;
    for (int it = 0; it < 300; it++) begin
      loop = 1'($urandom);
      r = int'($urandom_range(0, 10));
      case (r)
        0, 1: wr(BASE | 13'($urandom_range(0, 3)), {$urandom_range(0, 255), 6'd0, 2'($urandom)});
        2, 3, 4: wr(BASE | 13'h8 | 13'($urandom_range(0, 3)), $urandom);
        5: wr(BASE | 13'h4, $urandom & 32'h1E);
        6: begin
          a = 13'($urandom);
          wr(a, $urandom);
        end
        7: begin
          a = (($urandom_range(0, 3) == 0) ? 13'($urandom) : (BASE | 13'($urandom_range(0, 15))));
          rd(a, d);
        end
        8: repeat ($urandom_range(1, 40)) @(posedge clk);
        9: if ($urandom_range(0, 15) == 0) pulse_reset();
        default: wait_idle();
      endcase
    end
    wait_idle();
    repeat (4) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
